inst_mem_loader: RTL and testbench
==================================

Name: inst_mem_loader

Overview:
- Boot-time writer for the instruction memory; the initiating counterpart to the core's read-only instruction fetch path.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives a synchronous write port into the instruction memory array from address 0 upward.
- Holds the pipelined core in reset (cpu_hold) until the image is fully and correctly loaded.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory.
- DEPTH, 64, number of 32-bit words in the instruction memory; the maximum accepted word count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- load_start  input  1  one-cycle pulse; begins a load when in IDLE, DONE or ERR.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  ADDR_W  word address of the write.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  core reset request; high while not DONE.
- done  output  1  load completed successfully (level).
- error  output  1  load aborted (level).

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, state=IDLE, counters=0.
- Stream format: two header bytes giving word count N (16-bit, low byte first), then N words of 4 bytes each (low byte first).
- IDLE: in_ready=0. load_start moves to HDR_LO and clears done, error, the address counter and the byte counter.
- HDR_LO: in_ready=1. On transfer, latch N[7:0] and go to HDR_HI.
- HDR_HI: in_ready=1. On transfer, latch N[15:8]. Then:
  - full N > DEPTH: go to ERR.
  - N == 0: go to DONE.
  - otherwise: go to DATA.
- DATA: in_ready=1. Byte k of a word (k=0..3) is placed in wdata[8k+7:8k].
  - The cycle after the 4th byte's transfer: mem_we=1 for exactly one cycle, mem_addr=current word index, mem_wdata=assembled word.
  - The word index then increments.
  - After word N-1 is written, go to DONE (or CHK, see the optional feature).
- mem_addr never wraps, because N <= DEPTH is enforced.
- in_valid low stalls the loader with no state change. Gaps of any length are legal, including between the bytes of one word.
- DONE: in_ready=0, done=1, cpu_hold=0.
- ERR: in_ready=0, error=1, cpu_hold=1. Words already written stay in memory.
- load_start is ignored in HDR_LO, HDR_HI, DATA and CHK. In DONE or ERR it restarts the load and sets cpu_hold=1 on the next cycle.
- Reset asserted mid-load: immediate return to reset values. A partially assembled word is discarded and never written.
- mem_we is never asserted outside DATA/CHK sequencing.
- done and error are mutually exclusive.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte, the FSM enters CHK (in_ready=1) and accepts one checksum byte.
  - The expected value is the XOR of all payload bytes; header bytes are excluded.
  - Match goes to DONE; mismatch goes to ERR.
  - For N==0 the FSM still enters CHK, with expected value 0x00.
- Undefined: no CHK state, and DONE follows the last word write directly.

Decomposition:
- Shared package inst_loader_pkg holds:
  - the state enum (IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERR);
  - HDR_BYTES=2 and WORD_BYTES=4 constants.
- One sub-module, word_assembler:
  - 2-bit byte counter and 32-bit shift/placement register;
  - word_valid pulse on the 4th byte;
  - synchronous clear input.
- The top level keeps the FSM, header count, address counter and checksum.

Test Plan:
- Basic load: load_start, then bytes 02 00 93 00 c0 00 13 01 50 00 -> mem[0]=0x00c00093 and mem[1]=0x00500113, exactly 2 mem_we pulses, done=1, cpu_hold=0. With LOADER_CHECKSUM_EN, append 0x11 to get the same result.
- Checksum mismatch (macro on): same stream with trailing 0x12 -> error=1, cpu_hold=1, done=0; both words still written.
- Zero count: bytes 00 00 -> no mem_we, done=1 (macro on: extra byte 00 is required first).
- Over-size: bytes 41 00 (N=65) -> error=1, no mem_we, in_ready=0 afterwards.
- Backpressure: basic load with in_valid low for 3 cycles between every byte -> identical writes and addresses, one mem_we per word.
- Reset mid-load: rst_n low after the 5th byte accepted -> all outputs at reset values at once and no write to mem[0]. A following load_start plus the full stream loads correctly.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// LOADER_CHECKSUM_EN enables the trailing checksum byte and the CHK state.
package inst_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_LO = 3'd1,
      HDR_HI = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   // Running XOR parity over payload bytes.
   function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/inst_mem_loader_word_assembler.sv
// Collects four little-endian bytes into one 32-bit word; flags the word on its 4th byte.
module word_assembler
   import inst_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0]  cnt_r;
   logic [31:0] word_r;

   // Byte counter and shift register; newest byte enters at the top.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r  <= 2'd0;
         word_r <= 32'd0;
      end else if (clr) begin
         cnt_r  <= 2'd0;
         word_r <= 32'd0;
      end else if (byte_en) begin
         cnt_r  <= cnt_r + 2'd1;
         word_r <= {byte_in, word_r[31:8]};
      end else begin
         cnt_r  <= cnt_r;
         word_r <= word_r;
      end
   end

   // Completed word is presented combinationally alongside its final byte.
   always_comb begin
      word_valid = byte_en && (cnt_r == 2'(WORD_BYTES - 1));
      word       = {byte_in, word_r[31:8]};
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Boot-time loader: byte stream with a 16-bit word count header into instruction memory.
// Build option LOADER_CHECKSUM_EN appends an XOR checksum byte verified in state CHK.
module inst_mem_loader
   import inst_loader_pkg::*;
#(
   parameter int ADDR_W = 6,
   parameter int DEPTH  = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam logic [16:0] DEPTH_C = 17'(DEPTH);

   state_t              state_r, next_state_s;
   logic [7:0]          n_lo_r;
   logic [15:0]         n_r;
   logic [ADDR_W-1:0]   addr_r;
   logic                fire_s, start_s, byte_en_s, last_word_s;
   logic                word_valid_s;
   logic [31:0]         word_s;
   logic [15:0]         n_full_s;
   logic                in_ready_s, done_s, error_s, cpu_hold_s;
   logic                in_ready_r, mem_we_r, cpu_hold_r, done_r, error_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]          chk_r;
`endif

   assign fire_s      = in_valid && in_ready_r;
   assign start_s     = load_start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));
   assign byte_en_s   = fire_s && (state_r == DATA);
   assign n_full_s    = {in_data, n_lo_r};
   assign last_word_s = (16'(addr_r) == (n_r - 16'd1));

   word_assembler u_asm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (start_s),
      .byte_en    (byte_en_s),
      .byte_in    (in_data),
      .word_valid (word_valid_s),
      .word       (word_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE, DONE, ERR: begin
            if (load_start) next_state_s = HDR_LO;
            else            next_state_s = state_r;
         end
         HDR_LO: begin
            if (fire_s) next_state_s = HDR_HI;
            else        next_state_s = state_r;
         end
         HDR_HI: begin
            if (!fire_s) begin
               next_state_s = state_r;
            end else if ({1'b0, n_full_s} > DEPTH_C) begin
               next_state_s = ERR;
            end else if (n_full_s == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
               next_state_s = CHK;
`else
               next_state_s = DONE;
`endif
            end else begin
               next_state_s = DATA;
            end
         end
         DATA: begin
            if (word_valid_s && last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
               next_state_s = CHK;
`else
               next_state_s = DONE;
`endif
            end else begin
               next_state_s = state_r;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHK: begin
            if (!fire_s)               next_state_s = state_r;
            else if (in_data == chk_r) next_state_s = DONE;
            else                       next_state_s = ERR;
         end
`endif
         default: next_state_s = IDLE;
      endcase
   end

   // Status outputs decoded from the upcoming state so they can be registered.
   always_comb begin
      in_ready_s = (next_state_s == HDR_LO) || (next_state_s == HDR_HI) ||
                   (next_state_s == DATA)   || (next_state_s == CHK);
      done_s     = (next_state_s == DONE);
      error_s    = (next_state_s == ERR);
      cpu_hold_s = (next_state_s != DONE);
   end

   // Registered outputs; a write pulse follows the 4th byte of each word by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r  <= 1'b0;
         done_r      <= 1'b0;
         error_r     <= 1'b0;
         cpu_hold_r  <= 1'b1;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'd0;
      end else begin
         in_ready_r <= in_ready_s;
         done_r     <= done_s;
         error_r    <= error_s;
         cpu_hold_r <= cpu_hold_s;
         mem_we_r   <= word_valid_s;
         if (word_valid_s) begin
            mem_addr_r  <= addr_r;
            mem_wdata_r <= word_s;
         end
      end
   end

   // Header count, word index and payload checksum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_lo_r <= 8'd0;
         n_r    <= 16'd0;
         addr_r <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_r  <= 8'd0;
`endif
      end else if (start_s) begin
         n_lo_r <= 8'd0;
         n_r    <= 16'd0;
         addr_r <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_r  <= 8'd0;
`endif
      end else begin
         if (fire_s && (state_r == HDR_LO)) n_lo_r <= in_data;
         if (fire_s && (state_r == HDR_HI)) n_r <= n_full_s;
         if (word_valid_s) addr_r <= addr_r + 1'b1;
`ifdef LOADER_CHECKSUM_EN
         if (byte_en_s) chk_r <= chk_fold(chk_r, in_data);
`endif
      end
   end

   assign in_ready  = in_ready_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_hold  = cpu_hold_r;
   assign done      = done_r;
   assign error     = error_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader with a write scoreboard; honours LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst_n, load_start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready, mem_we, cpu_hold, done, error;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;

   typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
   wr_t         exp_q[$];
   logic [31:0] words [64];
   int          vectors = 0;
   int          miscompares = 0;
   int          we_cnt = 0;
   int          we_base;

   inst_mem_loader #(.ADDR_W(6), .DEPTH(64)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cycle; any write pulse seen is checked against the scoreboard.
   task automatic tick();
      wr_t e;
      @(negedge clk);
      if (mem_we === 1'b1) begin
         we_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_we", {26'd0, mem_addr}, 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {26'd0, mem_addr}, {26'd0, e.addr});
            chk("wr_data", mem_wdata, e.data);
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      else tick();
      in_valid = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic stream(input int n, input int gap, input logic [7:0] chk_flip);
      logic [7:0] x = 8'd0;
      logic [7:0] b;
      logic [15:0] nn = 16'(n);
      send_byte(nn[7:0], gap);
      send_byte(nn[15:8], gap);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{addr: 6'(i), data: words[i]});
         for (int k = 0; k < 4; k++) begin
            b = words[i][8*k +: 8];
            x = x ^ b;
            send_byte(b, gap);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(x ^ chk_flip, gap);
`endif
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input int nwr);
      repeat (3) tick();
      chk({tag, "_done"},  {31'd0, done},     {31'd0, d});
      chk({tag, "_error"}, {31'd0, error},    {31'd0, e});
      chk({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, ~d});
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_nwe"},   32'(we_cnt - we_base), 32'(nwr));
      chk({tag, "_qleft"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_we"},    {31'd0, mem_we},   32'd0);
      chk({tag, "_addr"},  {26'd0, mem_addr}, 32'd0);
      chk({tag, "_wdata"}, mem_wdata,         32'd0);
      chk({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
      chk({tag, "_done"},  {31'd0, done},     32'd0);
      chk({tag, "_error"}, {31'd0, error},    32'd0);
   endtask

   initial begin
      rst_n = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check_reset_vals("rst");

      // Basic two-word load.
      words[0] = 32'h00c00093;
      words[1] = 32'h00500113;
      we_base = we_cnt;
      pulse_start();
      stream(2, 0, 8'h00);
      check_status("basic", 1'b1, 1'b0, 2);

`ifdef LOADER_CHECKSUM_EN
      // Wrong checksum: words land, load reports error.
      we_base = we_cnt;
      pulse_start();
      stream(2, 0, 8'h03);
      check_status("badsum", 1'b0, 1'b1, 2);
`endif

      // Zero-length image.
      we_base = we_cnt;
      pulse_start();
      stream(0, 0, 8'h00);
      check_status("zero", 1'b1, 1'b0, 0);

      // N = 65 exceeds the memory.
      we_base = we_cnt;
      pulse_start();
      send_byte(8'h41, 0);
      send_byte(8'h00, 0);
      check_status("oversize", 1'b0, 1'b1, 0);

      // Backpressure: three idle cycles between every byte.
      we_base = we_cnt;
      pulse_start();
      stream(2, 3, 8'h00);
      check_status("gaps", 1'b1, 1'b0, 2);

      // Full-depth image with random contents, last address 63.
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      we_base = we_cnt;
      pulse_start();
      stream(64, 0, 8'h00);
      check_status("full", 1'b1, 1'b0, 64);

      // Reset after the 5th accepted byte; the partial word must never be written.
      words[0] = 32'h00c00093;
      words[1] = 32'h00500113;
      we_base = we_cnt;
      pulse_start();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h93, 0);
      send_byte(8'h00, 0);
      send_byte(8'hc0, 0);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("midrst_nwe", 32'(we_cnt - we_base), 32'd0);
      we_base = we_cnt;
      pulse_start();
      stream(2, 1, 8'h00);
      check_status("reload", 1'b1, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
